// File: rtl/mmu_feeder.sv
// mmu_feeder: sequences weight loads and activation streaming into a 3x3 systolic MMU,
// and tags the staggered per-column results for the accumulator.
module mmu_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int ARRAY_SIZE = 3
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         cmd_valid,
    output logic                                         cmd_ready,
    input  logic                                         cmd_load,
    input  logic                                         cmd_signed,
    input  logic [ARRAY_SIZE*ARRAY_SIZE*DATA_WIDTH-1:0]  cmd_weights,
    input  logic                                         act_valid,
    output logic                                         act_ready,
    input  logic [ARRAY_SIZE*DATA_WIDTH-1:0]             act_data,
    input  logic                                         act_last,
    output logic                                         en_weight_pass,
    output logic                                         en_capture_r0_c0,
    output logic                                         en_capture_r0_c1,
    output logic                                         en_capture_r0_c2,
    output logic                                         en_capture_r1_c0,
    output logic                                         en_capture_r1_c1,
    output logic                                         en_capture_r1_c2,
    output logic                                         en_capture_r2_c0,
    output logic                                         en_capture_r2_c1,
    output logic                                         en_capture_r2_c2,
    output logic                                         use_signed,
    output logic [DATA_WIDTH-1:0]                        row0_out,
    output logic [DATA_WIDTH-1:0]                        row1_out,
    output logic [DATA_WIDTH-1:0]                        row2_out,
    output logic [DATA_WIDTH-1:0]                        col0_out,
    output logic [DATA_WIDTH-1:0]                        col1_out,
    output logic [DATA_WIDTH-1:0]                        col2_out,
    output logic [2:0]                                   acc_valid,
    output logic [2:0]                                   acc_last,
    output logic                                         busy,
    output logic                                         done
);
    localparam int DW = DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DRAIN} state_t;

    state_t                                r_state, w_state_nxt;
    logic [2:0]                            r_cnt, w_cnt_nxt;
    logic [ARRAY_SIZE*ARRAY_SIZE*DW-1:0]   r_w;
    logic                                  r_signed;
    logic [4:0]                            r_vld, r_lst;
    logic                                  w_cmd_acc, w_act_acc, w_cap;
    logic [1:0]                            w_wrow;
    logic [DW-1:0]                         w_col [ARRAY_SIZE];

    assign w_cmd_acc = cmd_valid && cmd_ready;
    assign w_act_acc = act_valid && act_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: if (w_cmd_acc) begin
                w_state_nxt = cmd_load ? LOAD : COMPUTE;
                w_cnt_nxt   = '0;
            end
            LOAD: begin
                w_state_nxt = (r_cnt == 3'd2) ? COMPUTE : LOAD;
                w_cnt_nxt   = (r_cnt == 3'd2) ? 3'd0 : r_cnt + 3'd1;
            end
            COMPUTE: if (w_act_acc && act_last) begin
                w_state_nxt = DRAIN;
                w_cnt_nxt   = '0;
            end
            DRAIN: begin
                w_state_nxt = (r_cnt == 3'd4) ? IDLE : DRAIN;
                w_cnt_nxt   = (r_cnt == 3'd4) ? 3'd0 : r_cnt + 3'd1;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_w      <= '0;
            r_signed <= 1'b0;
            r_vld    <= '0;
            r_lst    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_vld   <= {r_vld[3:0], w_act_acc};
            r_lst   <= {r_lst[3:0], w_act_acc && act_last};
            if (w_cmd_acc) begin
                r_signed <= cmd_signed;
                if (cmd_load) r_w <= cmd_weights;
            end
        end
    end

    assign cmd_ready      = (r_state == IDLE);
    assign busy           = (r_state != IDLE);
    assign act_ready      = (r_state == COMPUTE);
    assign en_weight_pass = (r_state == LOAD);
    assign use_signed     = r_signed && busy;
    assign done           = (r_state == DRAIN) && (r_cnt == 3'd4);
    assign w_cap          = (r_state == LOAD) && (r_cnt == 3'd2);

    // Weights enter bottom row first so row r ends up holding W[r][*] after L2.
    assign w_wrow = 2'd2 - r_cnt[1:0];
    for (genvar c = 0; c < ARRAY_SIZE; c++) begin : g_col
        assign w_col[c] = (r_state == LOAD) ? r_w[(int'(w_wrow)*ARRAY_SIZE + c)*DW +: DW] : '0;
    end

    assign row0_out = w_act_acc ? act_data[0*DW +: DW] : '0;
    assign row1_out = w_act_acc ? act_data[1*DW +: DW] : '0;
    assign row2_out = w_act_acc ? act_data[2*DW +: DW] : '0;
    assign col0_out = w_col[0];
    assign col1_out = w_col[1];
    assign col2_out = w_col[2];

    assign en_capture_r0_c0 = w_cap;
    assign en_capture_r0_c1 = w_cap;
    assign en_capture_r0_c2 = w_cap;
    assign en_capture_r1_c0 = w_cap;
    assign en_capture_r1_c1 = w_cap;
    assign en_capture_r1_c2 = w_cap;
    assign en_capture_r2_c0 = w_cap;
    assign en_capture_r2_c1 = w_cap;
    assign en_capture_r2_c2 = w_cap;

    // Column c result leaves the array 3+c cycles after its vector enters.
    assign acc_valid = r_vld[4:2];
    assign acc_last  = r_lst[4:2];
endmodule

// File: tb/tb_mmu_feeder.sv
// tb_mmu_feeder: drives directed and random commands into mmu_feeder and compares every
// output each cycle against a timeline model of the command protocol.
module tb_mmu_feeder;
    logic        clk = 1'b0, rst = 1'b1;
    logic        cmd_valid = 1'b0, cmd_load = 1'b0, cmd_signed = 1'b0;
    logic [71:0] cmd_weights = '0;
    logic        act_valid = 1'b0, act_last = 1'b0;
    logic [23:0] act_data = '0;
    logic        cmd_ready, act_ready, en_weight_pass, use_signed, busy, done;
    logic [8:0]  cap;
    logic [7:0]  row0_out, row1_out, row2_out, col0_out, col1_out, col2_out;
    logic [2:0]  acc_valid, acc_last;

    bit [2:0]    ev [0:4095];
    bit [2:0]    el [0:4095];
    logic [24:0] vq [$];
    int          cyc = 0, n_chk = 0, n_fail = 0;
    logic [71:0] ident, all_ff, wr;

    always #5 clk = ~clk;

    mmu_feeder #(.DATA_WIDTH(8), .ARRAY_SIZE(3)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_load(cmd_load),
        .cmd_signed(cmd_signed), .cmd_weights(cmd_weights),
        .act_valid(act_valid), .act_ready(act_ready), .act_data(act_data), .act_last(act_last),
        .en_weight_pass(en_weight_pass),
        .en_capture_r0_c0(cap[0]), .en_capture_r0_c1(cap[1]), .en_capture_r0_c2(cap[2]),
        .en_capture_r1_c0(cap[3]), .en_capture_r1_c1(cap[4]), .en_capture_r1_c2(cap[5]),
        .en_capture_r2_c0(cap[6]), .en_capture_r2_c1(cap[7]), .en_capture_r2_c2(cap[8]),
        .use_signed(use_signed),
        .row0_out(row0_out), .row1_out(row1_out), .row2_out(row2_out),
        .col0_out(col0_out), .col1_out(col1_out), .col2_out(col2_out),
        .acc_valid(acc_valid), .acc_last(acc_last), .busy(busy), .done(done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic step(input bit e_cr, input bit e_ar, input bit e_ewp, input bit [8:0] e_cap,
                        input logic [23:0] e_rows, input logic [23:0] e_cols,
                        input bit e_busy, input bit e_sgn, input bit e_done);
        #1;
        check("cmd_ready", {31'b0, cmd_ready}, {31'b0, e_cr});
        check("act_ready", {31'b0, act_ready}, {31'b0, e_ar});
        check("en_weight_pass", {31'b0, en_weight_pass}, {31'b0, e_ewp});
        check("capture", {23'b0, cap}, {23'b0, e_cap});
        check("rows", {8'b0, row2_out, row1_out, row0_out}, {8'b0, e_rows});
        check("cols", {8'b0, col2_out, col1_out, col0_out}, {8'b0, e_cols});
        check("busy", {31'b0, busy}, {31'b0, e_busy});
        check("use_signed", {31'b0, use_signed}, {31'b0, e_sgn});
        check("done", {31'b0, done}, {31'b0, e_done});
        check("acc_valid", {29'b0, acc_valid}, {29'b0, ev[cyc]});
        check("acc_last", {29'b0, acc_last}, {29'b0, el[cyc]});
        @(negedge clk);
        cyc++;
    endtask

    // abort >= 0 asserts rst in that compute slot instead of finishing the command
    task automatic run_cmd(input bit load, input bit sgn, input logic [71:0] w,
                           input int nvec, input int bub, input int abort);
        int sent = 0, it = 0;
        bit v, last;
        logic [24:0] e;
        logic [23:0] cols;
        cmd_valid = 1'b1; cmd_load = load; cmd_signed = sgn; cmd_weights = w;
        act_valid = 1'($urandom); act_data = 24'($urandom); act_last = 1'($urandom);
        step(1, 0, 0, 9'h0, 24'h0, 24'h0, 0, 0, 0);
        cmd_valid = 1'b0; cmd_weights = {24'($urandom), 24'($urandom), 24'($urandom)};
        if (load) begin
            for (int k = 0; k < 3; k++) begin
                cols = {w[((2-k)*3+2)*8 +: 8], w[((2-k)*3+1)*8 +: 8], w[((2-k)*3)*8 +: 8]};
                act_valid = 1'($urandom); act_data = 24'($urandom);
                step(0, 0, 1, (k == 2) ? 9'h1ff : 9'h0, 24'h0, cols, 1, sgn, 0);
            end
        end
        while (sent < nvec) begin
            if (it == abort) begin
                rst = 1'b1; act_valid = 1'b1; act_data = 24'($urandom);
                @(negedge clk);
                cyc++;
                rst = 1'b0; act_valid = 1'b0;
                for (int i = 0; i < 8; i++) begin ev[cyc+i] = '0; el[cyc+i] = '0; end
                repeat (6) step(1, 0, 0, 9'h0, 24'h0, 24'h0, 0, 0, 0);
                return;
            end
            if (vq.size() > 0) begin
                e = vq.pop_front();
                v = !e[24];
                act_data = e[23:0];
            end else begin
                v = ($urandom_range(99) >= bub);
                act_data = 24'($urandom);
            end
            last = v && (sent == nvec - 1);
            act_valid = v;
            act_last = v ? last : 1'($urandom);
            if (v) begin
                for (int c = 0; c < 3; c++) begin
                    ev[cyc+3+c][c] = 1'b1;
                    el[cyc+3+c][c] = last;
                end
                sent++;
            end
            step(0, 1, 0, 9'h0, v ? act_data : 24'h0, 24'h0, 1, sgn, 0);
            it++;
        end
        for (int i = 0; i < 5; i++) begin
            act_valid = 1'($urandom); act_data = 24'($urandom); act_last = 1'($urandom);
            step(0, 0, 0, 9'h0, 24'h0, 24'h0, 1, sgn, i == 4);
        end
        act_valid = 1'b0; act_last = 1'b0;
    endtask

    initial begin
        ident  = 72'h010000000100000001;
        all_ff = {72{1'b1}};
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        step(1, 0, 0, 9'h0, 24'h0, 24'h0, 0, 0, 0);
        vq = '{25'h0030201};
        run_cmd(1, 0, ident, 1, 0, -1);
        vq = '{25'h0040302};
        run_cmd(1, 1, all_ff, 1, 0, -1);
        vq = '{25'h0000001, 25'h1000000, 25'h0000100};
        run_cmd(1, 0, ident, 2, 0, -1);
        vq = '{25'h0060504};
        run_cmd(0, 0, ident, 1, 0, -1);
        run_cmd(1, 1, ident, 4, 0, 2);
        run_cmd(0, 1, ident, 2, 20, -1);
        repeat (25) begin
            for (int j = 0; j < 9; j++) wr[j*8 +: 8] = 8'($urandom);
            run_cmd(1'($urandom), 1'($urandom), wr, $urandom_range(6, 1), $urandom_range(40), -1);
            repeat ($urandom_range(2)) step(1, 0, 0, 9'h0, 24'h0, 24'h0, 0, 0, 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
